fi_chain_loader: RTL
====================

Name: fi_chain_loader

Overview:
- Upstream controller for the saboteur scan chain inside the stereo-core fault-injection wrappers, for example Disp_Cmp with saboteurs.
- On a start command it shifts a WIDTH_SR-bit configuration word into the chain, LSB first.
- It then asserts the transient/fault enable for a programmed number of cycles and reports completion.
- Its outputs connect directly to the chain's i_SI, i_EN_SR and i_TFEn.

Parameters:
- WIDTH_SR, 131, saboteur chain length in bits; must be ≥ 1.
- CNT_W, 16, width of the fault-duration counter.

Ports:
- i_CLK_x  in  1  clock; all flops on the rising edge.
- i_RST_x  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start request; sampled only in IDLE.
- i_abort  in  1  cancels any operation.
- i_cfg_word  in  WIDTH_SR  configuration vector; bit k is shifted in the k-th shift cycle.
- i_fault_cycles  in  CNT_W  number of cycles o_TFEn is held high; 0 means load only.
- o_SI  out  1  serial configuration bit to the chain.
- o_EN_SR  out  1  chain shift enable.
- o_TFEn  out  1  fault-injection enable.
- o_busy  out  1  high from the cycle after an accepted start until the cycle after DONE.
- o_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (i_RST_x=0, asynchronous assert):
  - All outputs are 0.
  - FSM is in IDLE; counters are 0.
  - Reset mid-operation forces outputs to 0 immediately.
  - Release is synchronous to i_CLK_x.
- All outputs are registered and driven from FSM state.
- States: IDLE, SHIFT, INJECT, DONE.
- IDLE:
  - If i_start=1 and i_abort=0 at an edge, capture i_cfg_word into a shift buffer and latch i_fault_cycles.
  - Clear the bit counter and go to SHIFT.
  - Input changes after capture have no effect on the current operation.
- SHIFT:
  - o_EN_SR=1 and o_SI=buffer[k] during shift cycle k, for k=0..WIDTH_SR-1.
  - Exactly WIDTH_SR cycles; the chain samples o_SI at the edge ending each cycle.
  - After cycle WIDTH_SR-1, go to INJECT if the latched count is nonzero, else go to DONE.
- INJECT:
  - o_EN_SR=0, o_SI=0, o_TFEn=1 for exactly the latched count of cycles; the counter decrements.
  - Then go to DONE.
  - A count of 2^CNT_W-1 is legal; there is no wrap.
- DONE:
  - o_done=1 for one cycle with o_busy still 1; then go to IDLE.
- Latency:
  - o_EN_SR rises 1 cycle after the start edge.
  - With a nonzero count, o_done asserts 1+WIDTH_SR+N cycles after the start edge.
  - With a zero count, o_done asserts 1+WIDTH_SR cycles after the start edge.
- i_abort=1 at an edge in any non-IDLE state:
  - Next cycle is IDLE with all outputs 0.
  - No o_done pulse.
  - The chain is left partially loaded.
- Abort and start in the same cycle in IDLE: abort wins; start is ignored.
- i_start while o_busy=1 is ignored and not queued.
- A new start is accepted in the first IDLE cycle after DONE or after an abort.
- o_SI is 0 whenever o_EN_SR=0.

Optional Feature:
- Macro FI_READBACK_EN.
- When defined, the block adds:
  - input i_SO (1), the chain's serial output;
  - output o_mismatch (1);
  - output o_rb_valid (1).
- Shadow register:
  - A shadow register holds the last fully loaded word; it is 0 after reset.
- Comparison during SHIFT:
  - In shift cycle k, the block compares i_SO against shadow[k].
  - o_mismatch is sticky, cleared on an accepted start, and valid from DONE until the next start.
- Shadow update and validity:
  - The shadow is updated with the new word on entering DONE.
  - An abort marks the shadow invalid, so the next load has o_rb_valid=0 and o_mismatch is forced to 0.
  - The shadow becomes valid again after the next complete load.
- Without the macro: no extra ports and no shadow register.

Test Plan:
- Reset:
  - Hold i_RST_x=0 with i_start=1 → all outputs 0.
  - Assert reset in shift cycle 40 → o_EN_SR drops within the same cycle with no clock edge.
  - After release, start works normally.
- Single-bit load with injection:
  - Stimulus: cfg bit 83 set, fault_cycles=3, pulse start.
  - o_EN_SR is high for exactly 131 cycles.
  - o_SI=1 only in shift cycle 83.
  - o_TFEn is high for exactly 3 cycles.
  - o_done pulses at start+135; o_busy falls the cycle after.
- Load only: fault_cycles=0 with cfg=all ones → o_SI=1 for 131 cycles, o_TFEn never rises, o_done at start+132.
- Abort and start handling:
  - Abort in shift cycle 50 → o_EN_SR=0 next cycle, no o_done, o_busy=0.
  - A start 1 cycle later is accepted and completes normally.
- Start while busy: a start pulse during INJECT plus a change to i_cfg_word → ignored; the shifted data equals the originally captured word; exactly one o_done.
- With FI_READBACK_EN:
  - Load A, then load B with a chain model returning A → o_mismatch=0 and o_rb_valid=1.
  - Flip bit 7 of the model's return → o_mismatch=1 at DONE.
  - After an abort, the next load gives o_rb_valid=0 and o_mismatch=0.

Source files
------------

// File: rtl/fi_chain_loader.sv
// Loads a saboteur scan chain LSB first, holds the fault enable for a programmed
// number of cycles, then pulses done. Optional chain readback check: FI_READBACK_EN.
module fi_chain_loader #(
    parameter int WIDTH_SR = 131,
    parameter int CNT_W    = 16
) (
    input  logic                i_CLK_x,
    input  logic                i_RST_x,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [WIDTH_SR-1:0] i_cfg_word,
    input  logic [CNT_W-1:0]    i_fault_cycles,
`ifdef FI_READBACK_EN
    input  logic                i_SO,
    output logic                o_mismatch,
    output logic                o_rb_valid,
`endif
    output logic                o_SI,
    output logic                o_EN_SR,
    output logic                o_TFEn,
    output logic                o_busy,
    output logic                o_done
);

    localparam int BW = (WIDTH_SR > 1) ? $clog2(WIDTH_SR) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH_SR - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_INJECT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Rotating keeps the captured word intact after exactly WIDTH_SR shifts.
    function automatic logic [WIDTH_SR-1:0] rot_right(input logic [WIDTH_SR-1:0] v);
        return (v >> 1) | (v << (WIDTH_SR - 1));
    endfunction

    state_t              state_r, state_nx_s;
    logic [WIDTH_SR-1:0] buf_r, buf_nx_s;
    logic [BW-1:0]       bit_cnt_r, bit_cnt_nx_s;
    logic [CNT_W-1:0]    fcnt_r, fcnt_nx_s;
    logic                start_s, abort_s;
    logic                si_r, en_sr_r, tfen_r, busy_r, done_r;

    // Next-state, capture and counter logic.
    always_comb begin
        state_nx_s   = state_r;
        buf_nx_s     = buf_r;
        bit_cnt_nx_s = bit_cnt_r;
        fcnt_nx_s    = fcnt_r;
        start_s      = 1'b0;
        abort_s      = i_abort && (state_r != ST_IDLE);
        if (abort_s) begin
            state_nx_s   = ST_IDLE;
            bit_cnt_nx_s = '0;
            fcnt_nx_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        start_s      = 1'b1;
                        buf_nx_s     = i_cfg_word;
                        fcnt_nx_s    = i_fault_cycles;
                        bit_cnt_nx_s = '0;
                        state_nx_s   = ST_SHIFT;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    buf_nx_s = rot_right(buf_r);
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_nx_s = '0;
                        state_nx_s   = (fcnt_r != '0) ? ST_INJECT : ST_DONE;
                    end else begin
                        bit_cnt_nx_s = bit_cnt_r + BW'(1);
                    end
                end
                ST_INJECT: begin
                    fcnt_nx_s = fcnt_r - CNT_W'(1);
                    if (fcnt_r == CNT_W'(1)) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_INJECT;
                    end
                end
                ST_DONE:  state_nx_s = ST_IDLE;
                default:  state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, buffer and counter registers.
    always_ff @(posedge i_CLK_x or negedge i_RST_x) begin
        if (!i_RST_x) begin
            state_r   <= ST_IDLE;
            buf_r     <= '0;
            bit_cnt_r <= '0;
            fcnt_r    <= '0;
        end else begin
            state_r   <= state_nx_s;
            buf_r     <= buf_nx_s;
            bit_cnt_r <= bit_cnt_nx_s;
            fcnt_r    <= fcnt_nx_s;
        end
    end

    // Registered outputs decoded from the current state; abort zeroes them at once.
    always_ff @(posedge i_CLK_x or negedge i_RST_x) begin
        if (!i_RST_x) begin
            si_r    <= 1'b0;
            en_sr_r <= 1'b0;
            tfen_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            en_sr_r <= !abort_s && (state_r == ST_SHIFT);
            si_r    <= !abort_s && (state_r == ST_SHIFT) && buf_r[0];
            tfen_r  <= !abort_s && (state_r == ST_INJECT);
            done_r  <= !abort_s && (state_r == ST_DONE);
            busy_r  <= (state_nx_s != ST_IDLE) || (!abort_s && (state_r == ST_DONE));
        end
    end

    assign o_SI    = si_r;
    assign o_EN_SR = en_sr_r;
    assign o_TFEn  = tfen_r;
    assign o_done  = done_r;
    assign o_busy  = busy_r;

`ifdef FI_READBACK_EN
    logic [WIDTH_SR-1:0] shadow_r, sh_cmp_r;
    logic                valid_r, rb_valid_r, mismatch_r;

    // Chain readback: compare returned bits against the previously loaded word.
    always_ff @(posedge i_CLK_x or negedge i_RST_x) begin
        if (!i_RST_x) begin
            shadow_r   <= '0;
            sh_cmp_r   <= '0;
            valid_r    <= 1'b1;
            rb_valid_r <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            if (start_s) begin
                sh_cmp_r   <= shadow_r;
                rb_valid_r <= valid_r;
                mismatch_r <= 1'b0;
            end else if (en_sr_r) begin
                sh_cmp_r   <= rot_right(sh_cmp_r);
                mismatch_r <= mismatch_r | (rb_valid_r & (i_SO ^ sh_cmp_r[0]));
            end else begin
                mismatch_r <= mismatch_r;
            end
            if ((state_r != ST_DONE) && (state_nx_s == ST_DONE)) begin
                shadow_r <= buf_nx_s;
                valid_r  <= 1'b1;
            end else if (abort_s) begin
                valid_r  <= 1'b0;
            end else begin
                valid_r  <= valid_r;
            end
        end
    end

    assign o_mismatch = mismatch_r;
    assign o_rb_valid = rb_valid_r;
`endif

endmodule
